// File: rtl/imem_pkg.sv
// imem_pkg: shared types and defaults for the fetch-stage instruction memory.
//   imem_fault_e    - fault code returned alongside every fetch response
//   IMEM_BASE_ADDR  - default byte address of storage word 0
//   IMEM_NOP_WORD   - default instruction returned with a faulted fetch
package imem_pkg;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10
  } imem_fault_e;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] IMEM_NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: 2-entry response buffer with valid/ready output and flush.
//   clk, reset   - clock, synchronous active-high reset
//   flush        - drop every buffered entry at the next edge
//   in_valid     - push in_data this cycle (caller guarantees room)
//   in_data      - entry to push ({fault, instr} in the fetch unit)
//   out_valid    - head entry present
//   out_ready    - head entry consumed when out_valid && out_ready
//   out_data     - head entry, stable until consumed
//   count        - entries currently held (0..2)
module imem_rsp_fifo #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = ent_q[rd_ptr_q];
  assign count     = count_q;
  assign push      = in_valid;
  assign pop       = out_valid && out_ready;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + 2'(push) - 2'(pop);
    if (push) begin
      ent_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Flush wins over a same-cycle push: the in-flight word is discarded too.
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) ent_q[i] <= ent_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: synchronous instruction memory for the fetch stage.
//   Byte-addressed, word-aligned fetches into a window starting at BASE_ADDR.
//   Each accepted request spends one cycle in the RAM read stage, then enters a
//   2-entry response buffer; at most two responses are outstanding in total.
//   clk, reset             - clock, synchronous active-high reset
//   req_valid/ready/addr   - fetch request handshake and byte address
//   rsp_valid/ready        - response handshake
//   rsp_instr, rsp_fault   - instruction (NOP_WORD on fault) and fault code
//   flush                  - discard everything in flight or buffered
//   ld_en/idx/data         - backdoor word write for loading program images
module imem_fetch
  import imem_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 256,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(IMEM_BASE_ADDR),
  parameter logic [DATA_W-1:0]  NOP_WORD  = DATA_W'(IMEM_NOP_WORD),
  parameter string              INIT_FILE = "",
  localparam int                IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  logic              inflight_q, inflight_d;
  imem_fault_e       fault_q, fault_d;

  imem_fault_e       dec_fault;
  logic [IDX_W-1:0]  dec_idx;
  logic [ADDR_W:0]   addr_ext, base_ext, limit_ext;
  logic              accept;
  logic [1:0]        fifo_count;
  logic [1:0]        occupancy;
  logic [DATA_W+1:0] push_data;
  logic [DATA_W+1:0] head_data;

  // Window bounds are compared one bit wider so BASE_ADDR+4*DEPTH cannot wrap.
  assign addr_ext  = {1'b0, req_addr};
  assign base_ext  = {1'b0, BASE_ADDR};
  assign limit_ext = base_ext + (ADDR_W+1)'(4 * DEPTH);
  assign dec_idx   = IDX_W'((req_addr - BASE_ADDR) >> 2);

  always_comb begin
    dec_fault = FLT_NONE;
    if (req_addr[1:0] != 2'b00) begin
      dec_fault = FLT_MISALIGN;
    end else if ((addr_ext < base_ext) || (addr_ext >= limit_ext)) begin
      dec_fault = FLT_RANGE;
    end
  end

  // A pop this cycle frees a slot, so a full buffer can still take a request.
  assign occupancy = 2'(inflight_q) + fifo_count;
  assign req_ready = !reset && !flush &&
                     ((occupancy < 2'd2) || (rsp_valid && rsp_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    inflight_d = accept;
    fault_d    = fault_q;
    if (accept) fault_d = dec_fault;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      fault_q    <= FLT_NONE;
    end else begin
      inflight_q <= inflight_d;
      fault_q    <= fault_d;
    end
  end

  // Single read port, single write port. Non-blocking update of mem makes a
  // same-cycle read of the written word return the old contents.
  always_ff @(posedge clk) begin
    if (accept && (dec_fault == FLT_NONE)) rd_data_q <= mem[dec_idx];
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  assign push_data = {fault_q, (fault_q == FLT_NONE) ? rd_data_q : NOP_WORD};

  imem_rsp_fifo #(
    .W (DATA_W + 2)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (inflight_q),
    .in_data   (push_data),
    .out_valid (rsp_valid),
    .out_ready (rsp_ready),
    .out_data  (head_data),
    .count     (fifo_count)
  );

  assign rsp_instr = head_data[DATA_W-1:0];
  assign rsp_fault = head_data[DATA_W+1:DATA_W];

endmodule
